// File: rtl/jtkcpu_pkg.sv
// Shared definitions for the JTKCPU memory sequencer: interrupt vector
// addresses, sequencer state encoding and the vector priority encoder.
package jtkcpu_pkg;

    // Vector table addresses (high byte of each vector lives here, low byte at +1)
    localparam logic [15:0] VEC_IRQ  = 16'hFFF8;
    localparam logic [15:0] VEC_FIRQ = 16'hFFF6;
    localparam logic [15:0] VEC_NMI  = 16'hFFFC;
    localparam logic [15:0] VEC_RST  = 16'hFFFE;

    // A vector fetch is always a two-byte incrementing read
    localparam int VEC_LEN = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // Priority encode the vector request bits: RST > NMI > FIRQ > IRQ.
    // Only meaningful when at least one bit is set.
    function automatic logic [15:0] vec_addr(input logic [3:0] vec);
        logic [15:0] a;
        if (vec[3]) begin
            a = VEC_RST;
        end else if (vec[2]) begin
            a = VEC_NMI;
        end else if (vec[1]) begin
            a = VEC_FIRQ;
        end else begin
            a = VEC_IRQ;
        end
        return a;
    endfunction

endpackage

// File: rtl/jtkcpu_memseq_pack.sv
// Byte lane handling for the sequencer: picks the outgoing write byte and
// merges an incoming read byte into the accumulated read word.
module jtkcpu_memseq_pack #(
    parameter int MAXB = 2,
    parameter int CW   = 2
) (
    input  logic [8*MAXB-1:0] wdata,    // write word, right-aligned
    input  logic [CW-1:0]     wlen,     // bytes in the write transfer
    input  logic [CW-1:0]     widx,     // byte number being presented
    input  logic              wdec,     // 1: LSB first, 0: MSB first
    input  logic [8*MAXB-1:0] acc,      // read data gathered so far
    input  logic [7:0]        din,      // byte arriving from the bus
    input  logic [CW-1:0]     ridx,     // byte number arriving
    input  logic              rdec,     // 1: insert by lane, 0: shift in
    output logic [7:0]        wbyte,
    output logic [8*MAXB-1:0] acc_next
);

    logic [7:0]        wlane [MAXB];
    logic [8*MAXB-1:0] dec_acc;
    logic [8*MAXB-1:0] inc_acc;
    logic [CW-1:0]     wsel;

    // Split the write word into lanes and build the lane-insert read word
    generate
        for (genvar gi = 0; gi < MAXB; gi++) begin : g_lane
            assign wlane[gi] = wdata[8*gi +: 8];
            assign dec_acc[8*gi +: 8] = (ridx == CW'(gi)) ? din : acc[8*gi +: 8];
        end
    endgenerate

    // Big-endian reads shift earlier bytes up and append the new one
    assign inc_acc  = (acc << 8) | (8*MAXB)'(din);
    assign acc_next = rdec ? dec_acc : inc_acc;

    // Select the write lane: increment sends MSB of the used bytes first
    always_comb begin
        wbyte = '0;
        wsel  = wdec ? widx : (wlen - CW'(1) - widx);
        for (int k = 0; k < MAXB; k++) begin
            if (wsel == CW'(k)) begin
                wbyte = wlane[k];
            end
        end
    end

endmodule

// File: rtl/jtkcpu_memseq.sv
// Multi-byte memory access sequencer: turns one request into consecutive
// byte cycles on the 8-bit bus, with wait states, back-to-back requests and
// prioritised interrupt vector fetches.
module jtkcpu_memseq
    import jtkcpu_pkg::*;
#(
    parameter int AW   = 16,
    parameter int MAXB = 2,
    parameter int LW   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    input  logic              req,
    input  logic              req_we,
    input  logic              req_dec,
    input  logic [AW-1:0]     req_addr,
    input  logic [LW-1:0]     req_len,
    input  logic [8*MAXB-1:0] req_wdata,
    input  logic [3:0]        req_vec,
    output logic              ack,
    output logic              busy,
    output logic              done,
    output logic              is_vec,
    output logic [8*MAXB-1:0] rdata,
    output logic [AW-1:0]     addr,
    output logic [7:0]        dout,
    input  logic [7:0]        din,
    output logic              cs,
    output logic              we,
    input  logic              bus_ok
);

    localparam int CW = $clog2(MAXB) + 1;
    localparam int DW = 8 * MAXB;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   len_q, len_d;
    logic            dec_q, dec_d;
    logic            opwe_q, opwe_d;
    logic            vec_q, vec_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic            ack_q, ack_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            is_vec_q, is_vec_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [7:0]      dout_q, dout_d;
    logic            cs_q, cs_d;
    logic            we_q, we_d;

    logic            vec_hit;
    logic            accept_any;
    logic [CW-1:0]   clip_len;
    logic [CW-1:0]   new_len;
    logic            new_we;
    logic            new_dec;
    logic [DW-1:0]   new_wdata;
    logic [AW-1:0]   new_addr;
    logic            complete;
    logic            last_byte;
    logic            start_now;
    logic [CW-1:0]   cnt_inc;
    logic [DW-1:0]   p_wdata;
    logic [CW-1:0]   p_wlen;
    logic [CW-1:0]   p_widx;
    logic            p_wdec;
    logic [7:0]      wbyte;
    logic [DW-1:0]   acc_next;

    // Decode the incoming request; a vector fetch overrides every req field
    always_comb begin
        vec_hit    = |req_vec;
        accept_any = req | vec_hit;
        if (req_len == '0) begin
            clip_len = CW'(1);
        end else if (int'(req_len) > MAXB) begin
            clip_len = CW'(MAXB);
        end else begin
            clip_len = CW'(req_len);
        end
        new_len   = vec_hit ? CW'(VEC_LEN) : clip_len;
        new_we    = ~vec_hit & req_we;
        new_dec   = ~vec_hit & req_dec;
        new_wdata = vec_hit ? '0 : req_wdata;
        if (vec_hit) begin
            new_addr = AW'(vec_addr(req_vec));
        end else if (req_dec) begin
            new_addr = req_addr - AW'(1);
        end else begin
            new_addr = req_addr;
        end
    end

    // Edge qualifiers: byte completion, last byte, and acceptance
    always_comb begin
        cnt_inc   = cnt_q + CW'(1);
        complete  = cen & (state_q == ST_ACCESS) & bus_ok;
        last_byte = complete & (cnt_q == len_q - CW'(1));
        start_now = cen & accept_any & ((state_q == ST_IDLE) | last_byte);
    end

    // Write byte source: new request's byte 0 on acceptance, else next latched byte
    always_comb begin
        p_wdata = start_now ? new_wdata : wdata_q;
        p_wlen  = start_now ? new_len   : len_q;
        p_widx  = start_now ? '0        : cnt_inc;
        p_wdec  = start_now ? new_dec   : dec_q;
    end

    jtkcpu_memseq_pack #(
        .MAXB (MAXB),
        .CW   (CW)
    ) u_pack (
        .wdata    (p_wdata),
        .wlen     (p_wlen),
        .widx     (p_widx),
        .wdec     (p_wdec),
        .acc      (acc_q),
        .din      (din),
        .ridx     (cnt_q),
        .rdec     (dec_q),
        .wbyte    (wbyte),
        .acc_next (acc_next)
    );

    // Next-state and output logic; everything holds while cen is low
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        dec_d    = dec_q;
        opwe_d   = opwe_q;
        vec_d    = vec_q;
        wdata_d  = wdata_q;
        acc_d    = acc_q;
        ack_d    = ack_q;
        busy_d   = busy_q;
        done_d   = done_q;
        is_vec_d = is_vec_q;
        rdata_d  = rdata_q;
        addr_d   = addr_q;
        dout_d   = dout_q;
        cs_d     = cs_q;
        we_d     = we_q;

        if (cen) begin
            ack_d    = 1'b0;
            done_d   = 1'b0;
            is_vec_d = 1'b0;
        end

        if (complete) begin
            if (!opwe_q) begin
                acc_d = acc_next;
            end
            if (last_byte) begin
                done_d   = 1'b1;
                is_vec_d = vec_q;
                rdata_d  = opwe_q ? '0 : acc_next;
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
                cs_d     = 1'b0;
                we_d     = 1'b0;
                dout_d   = '0;
            end else begin
                cnt_d  = cnt_inc;
                addr_d = dec_q ? (addr_q - AW'(1)) : (addr_q + AW'(1));
                dout_d = opwe_q ? wbyte : 8'h00;
            end
        end

        // Acceptance overrides the idle return, giving zero-bubble chaining
        if (start_now) begin
            state_d = ST_ACCESS;
            ack_d   = 1'b1;
            busy_d  = 1'b1;
            cs_d    = 1'b1;
            we_d    = new_we;
            cnt_d   = '0;
            len_d   = new_len;
            dec_d   = new_dec;
            opwe_d  = new_we;
            vec_d   = vec_hit;
            wdata_d = new_wdata;
            acc_d   = '0;
            addr_d  = new_addr;
            dout_d  = new_we ? wbyte : 8'h00;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            len_q    <= '0;
            dec_q    <= 1'b0;
            opwe_q   <= 1'b0;
            vec_q    <= 1'b0;
            wdata_q  <= '0;
            acc_q    <= '0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            is_vec_q <= 1'b0;
            rdata_q  <= '0;
            addr_q   <= '0;
            dout_q   <= '0;
            cs_q     <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            dec_q    <= dec_d;
            opwe_q   <= opwe_d;
            vec_q    <= vec_d;
            wdata_q  <= wdata_d;
            acc_q    <= acc_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            is_vec_q <= is_vec_d;
            rdata_q  <= rdata_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
            cs_q     <= cs_d;
            we_q     <= we_d;
        end
    end

    assign ack    = ack_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign is_vec = is_vec_q;
    assign rdata  = rdata_q;
    assign addr   = addr_q;
    assign dout   = dout_q;
    assign cs     = cs_q;
    assign we     = we_q;

endmodule

// File: tb/tb_jtkcpu_memseq.sv
// Directed bench for jtkcpu_memseq with a byte-wide memory model on the bus.
module tb_jtkcpu_memseq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cen;
    logic        req;
    logic        req_we;
    logic        req_dec;
    logic [15:0] req_addr;
    logic [2:0]  req_len;
    logic [15:0] req_wdata;
    logic [3:0]  req_vec;
    logic        ack;
    logic        busy;
    logic        done;
    logic        is_vec;
    logic [15:0] rdata;
    logic [15:0] addr;
    logic [7:0]  dout;
    logic [7:0]  din;
    logic        cs;
    logic        we;
    logic        bus_ok;

    logic [7:0]  mem [0:65535];

    int n_checks = 0;
    int n_pass   = 0;

    jtkcpu_memseq #(.AW(16), .MAXB(2), .LW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .req       (req),
        .req_we    (req_we),
        .req_dec   (req_dec),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_wdata (req_wdata),
        .req_vec   (req_vec),
        .ack       (ack),
        .busy      (busy),
        .done      (done),
        .is_vec    (is_vec),
        .rdata     (rdata),
        .addr      (addr),
        .dout      (dout),
        .din       (din),
        .cs        (cs),
        .we        (we),
        .bus_ok    (bus_ok)
    );

    always #5 clk = ~clk;

    assign din = mem[addr];

    // Memory model accepts a write byte on each completing bus edge
    always @(posedge clk) begin
        if (!rst && cen && cs && we && bus_ok) begin
            mem[addr] <= dout;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle just past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we_i, input logic dec_i, input logic [15:0] a,
                         input logic [2:0] len, input logic [15:0] wd);
        req       = 1'b1;
        req_we    = we_i;
        req_dec   = dec_i;
        req_addr  = a;
        req_len   = len;
        req_wdata = wd;
    endtask

    // Vector fetch with the expected table address and stored vector
    task automatic run_vec(input logic [3:0] v, input logic [15:0] vaddr, input logic [15:0] vdata);
        bit seen;
        req_vec = v;
        tick();
        check("vec_addr0", addr, vaddr);
        check("vec_ack", ack, 1);
        req_vec = 4'b0000;
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if (done) seen = 1;
        end
        check("vec_done_seen", seen, 1);
        check("vec_is_vec", is_vec, 1);
        check("vec_rdata", rdata, vdata);
        $display("vec %b addr %h rdata %h", v, vaddr, rdata);
    endtask

    initial begin
        rst = 1'b1; cen = 1'b1; req = 1'b0; req_we = 1'b0; req_dec = 1'b0;
        req_addr = '0; req_len = '0; req_wdata = '0; req_vec = '0; bus_ok = 1'b1;
        mem[16'h1234] = 8'hAB; mem[16'h1235] = 8'hCD;
        mem[16'h2000] = 8'h5A; mem[16'h2001] = 8'h77;
        mem[16'h3000] = 8'h11; mem[16'h3001] = 8'h22;
        mem[16'hFFFF] = 8'h9A; mem[16'h0000] = 8'hBC;
        mem[16'hFFFE] = 8'hC0; mem[16'h4000] = 8'hE5;
        mem[16'hFFFC] = 8'h12; mem[16'hFFFD] = 8'h34;
        mem[16'hFFF6] = 8'h56; mem[16'hFFF7] = 8'h78;
        mem[16'hFFF8] = 8'h9A; mem[16'hFFF9] = 8'hBC;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_is_vec", is_vec, 0);
        check("rst_rdata", rdata, 0);
        check("rst_addr", addr, 0);
        check("rst_dout", dout, 0);
        check("rst_cs", cs, 0);
        check("rst_we", we, 0);

        // Incrementing two-byte read
        issue(0, 0, 16'h1234, 3'd2, 16'h0000);
        tick();
        check("rd_ack", ack, 1);
        check("rd_busy", busy, 1);
        check("rd_cs", cs, 1);
        check("rd_addr0", addr, 16'h1234);
        check("rd_we", we, 0);
        req = 1'b0;
        tick();
        check("rd_addr1", addr, 16'h1235);
        check("rd_ack_drop", ack, 0);
        check("rd_done_early", done, 0);
        tick();
        check("rd_done", done, 1);
        check("rd_rdata", rdata, 16'hABCD);
        check("rd_busy_end", busy, 0);
        check("rd_cs_end", cs, 0);
        $display("read inc 1234 len 2 rdata %h", rdata);
        tick();
        check("rd_done_pulse", done, 0);

        // Pre-decrement push write
        issue(1, 1, 16'h0100, 3'd2, 16'hBEEF);
        tick();
        check("push_addr0", addr, 16'h00FF);
        check("push_dout0", dout, 8'hEF);
        check("push_we0", we, 1);
        req = 1'b0;
        tick();
        check("push_addr1", addr, 16'h00FE);
        check("push_dout1", dout, 8'hBE);
        check("push_we1", we, 1);
        tick();
        check("push_done", done, 1);
        check("push_we_end", we, 0);
        check("push_mem_ff", mem[16'h00FF], 8'hEF);
        check("push_mem_fe", mem[16'h00FE], 8'hBE);
        $display("write dec 0100 len 2 wdata BEEF");

        // Incrementing write sends MSB first
        issue(1, 0, 16'h5000, 3'd2, 16'hA1B2);
        tick();
        check("wr_dout0", dout, 8'hA1);
        req = 1'b0;
        tick();
        check("wr_addr1", addr, 16'h5001);
        check("wr_dout1", dout, 8'hB2);
        tick();
        check("wr_done", done, 1);
        check("wr_mem0", mem[16'h5000], 8'hA1);
        check("wr_mem1", mem[16'h5001], 8'hB2);
        $display("write inc 5000 len 2 wdata A1B2");

        // Single-byte read with three wait states
        issue(0, 0, 16'h2000, 3'd1, 16'h0000);
        bus_ok = 1'b0;
        tick();
        check("ws_addr0", addr, 16'h2000);
        req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ws_cs_hold", cs, 1);
            check("ws_addr_hold", addr, 16'h2000);
            check("ws_no_done", done, 0);
        end
        bus_ok = 1'b1;
        tick();
        check("ws_done", done, 1);
        check("ws_rdata", rdata, 16'h005A);
        $display("read 2000 len 1 waits 3 rdata %h", rdata);

        // Zero length behaves as one byte
        issue(0, 0, 16'h2001, 3'd0, 16'h0000);
        tick();
        req = 1'b0;
        tick();
        check("len0_done", done, 1);
        check("len0_rdata", rdata, 16'h0077);
        $display("read 2001 len 0 rdata %h", rdata);

        // Clock enable low freezes every output
        issue(0, 0, 16'h3000, 3'd2, 16'h0000);
        tick();
        req = 1'b0;
        cen = 1'b0;
        tick(); tick();
        check("cen_ack_hold", ack, 1);
        check("cen_addr_hold", addr, 16'h3000);
        cen = 1'b1;
        tick();
        check("cen_addr1", addr, 16'h3001);
        check("cen_ack_drop", ack, 0);
        tick();
        check("cen_done", done, 1);
        check("cen_rdata", rdata, 16'h1122);
        $display("read 3000 len 2 with cen stall rdata %h", rdata);

        // Address wrap at the top, with an over-long length clipped to two
        issue(0, 0, 16'hFFFF, 3'd7, 16'h0000);
        tick();
        check("wrap_addr0", addr, 16'hFFFF);
        req = 1'b0;
        tick();
        check("wrap_addr1", addr, 16'h0000);
        tick();
        check("wrap_done", done, 1);
        check("wrap_rdata", rdata, 16'h9ABC);
        $display("read FFFF len 7 rdata %h", rdata);

        // RST vector beats a pending request, which then chains with no gap
        issue(0, 0, 16'h4000, 3'd1, 16'h0000);
        req_vec = 4'b1001;
        tick();
        check("rstv_addr0", addr, 16'hFFFE);
        check("rstv_we", we, 0);
        req_vec = 4'b0000;
        tick();
        check("rstv_addr1", addr, 16'hFFFF);
        check("rstv_no_ack", ack, 0);
        tick();
        check("rstv_done", done, 1);
        check("rstv_is_vec", is_vec, 1);
        check("rstv_rdata", rdata, 16'hC09A);
        check("chain_ack", ack, 1);
        check("chain_cs", cs, 1);
        check("chain_busy", busy, 1);
        check("chain_addr", addr, 16'h4000);
        $display("vec 1001 addr FFFE rdata %h chained req 4000", rdata);
        req = 1'b0;
        tick();
        check("chain_done", done, 1);
        check("chain_is_vec", is_vec, 0);
        check("chain_rdata", rdata, 16'h00E5);
        check("chain_busy_end", busy, 0);
        $display("read 4000 len 1 rdata %h", rdata);

        // Vector priorities
        run_vec(4'b0101, 16'hFFFC, 16'h1234);
        run_vec(4'b0011, 16'hFFF6, 16'h5678);
        run_vec(4'b0001, 16'hFFF8, 16'h9ABC);

        // Reset in the middle of a transfer
        issue(0, 0, 16'h1234, 3'd2, 16'h0000);
        tick();
        check("mid_cs_before", cs, 1);
        req = 1'b0;
        rst = 1'b1;
        tick();
        check("mid_cs", cs, 0);
        check("mid_we", we, 0);
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        rst = 1'b0;
        tick();
        check("mid_done_after", done, 0);
        check("mid_rdata", rdata, 0);
        $display("read 1234 len 2 aborted by reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/jtkcpu_memseq.md
# jtkcpu_memseq

Parametrised multi-byte memory access sequencer for the JTKCPU core, generalising the first-generation controller: it turns one request (1..MAXB bytes, read or write, incrementing or pre-decrementing address) into consecutive byte bus cycles. It adds bus wait states, zero-bubble back-to-back requests and prioritised interrupt-vector fetch. It sits between the control unit/ALU/stack logic and the 8-bit external memory bus.

## Interface
- AW, 16, address width
- MAXB, 2, maximum bytes per request (1..4)
- LW, 3, width of `req_len`

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cen  in  1  clock enable; all state advances only on clk edges with cen=1
- req  in  1  transfer request, level; sampled when idle or on the completing edge
- req_we  in  1  1=write, 0=read
- req_dec  in  1  1=pre-decrement (stack push) addressing, 0=increment
- req_addr  in  AW  start address
- req_len  in  LW  byte count; 0 treated as 1, values >MAXB clipped to MAXB
- req_wdata  in  8*MAXB  write data, right-aligned
- req_vec  in  4  interrupt vector fetch: bit0 IRQ, bit1 FIRQ, bit2 NMI, bit3 RST
- ack  out  1  request accepted (one cen period)
- busy  out  1  transfer in progress
- done  out  1  transfer complete, `rdata` valid (one cen period)
- is_vec  out  1  qualifies `done` as a vector fetch
- rdata  out  8*MAXB  read data, right-aligned, unused upper bytes zero
- addr  out  AW  bus address
- dout  out  8  bus write data
- din  in  8  bus read data
- cs  out  1  bus cycle active
- we  out  1  bus write strobe, only with cs
- bus_ok  in  1  current bus cycle completes on this cen edge (0 = wait state)

## Operation
- States: IDLE, ACCESS. IDLE→ACCESS on cen edge with req or any req_vec bit; ACCESS→IDLE on the cen edge where the last byte completes and no new request is pending; otherwise ACCESS re-arms with the new request.
- Priority on acceptance: req_vec over req. Among vector bits, RST > NMI > FIRQ > IRQ.
- Vector fetch: read, 2 bytes, increment, addresses IRQ FFF8, FIRQ FFF6, NMI FFFC, RST FFFE; req fields ignored.
- Increment mode: byte i at req_addr+i, big-endian. Writes send MSB first; reads shift left 8 and OR din.
- Decrement mode: byte i at req_addr−1−i, LSB first. Writes send req_wdata[8i+:8]; reads place din in rdata[8i+:8].
- Address arithmetic is modulo 2^AW: FFFF+1 wraps to 0000, 0000−1 to FFFF.
- Request fields are latched on acceptance; changes during ACCESS are ignored.
- A byte advances only on a cen edge with bus_ok=1. addr, dout, we and cs hold during wait states.

## Timing
- Reset values: state IDLE, ack=0, busy=0, done=0, is_vec=0, rdata=0, addr=0, dout=0, cs=0, we=0. Reset mid-transfer drops cs/we on the next clk edge and discards partial data. No done is issued.
- Acceptance on cen edge t0: ack, busy and cs high from t0. addr/dout/we present byte 0 from t0.
- N bytes, W total wait states: last byte completes at edge t(N+W). done, rdata and is_vec update there. done and ack each last exactly one cen period.
- busy falls at the completing edge unless a request is accepted on that same edge. In that case ack=1, done=1, and cs stays high with the new byte 0: zero-bubble back-to-back.
- While busy outside the completing edge, req is not sampled and ack stays 0.
- cen=0: every output holds its value.

## Structure
- Package jtkcpu_pkg: vector address constants (FIRQ/IRQ/NMI/RST), state encoding, and the priority-encode function for req_vec.
- One natural sub-module, jtkcpu_memseq_pack: byte select for writes and shift/insert for reads, parametrised by MAXB.
- Byte counter width: clog2(MAXB)+1.

## Test plan
- Read, len=2, inc, addr 1234, memory 1234=AB 1235=CD, bus_ok=1 → addr 1234 then 1235 on consecutive cen periods; done at edge t2; rdata=ABCD.
- Push write, len=2, dec, addr 0100, wdata BEEF → cycle 1 addr 00FF dout EF we=1; cycle 2 addr 00FE dout BE; done at t2.
- Read, len=1, bus_ok low for 3 cen periods → addr/cs held 4 periods; done at t4; len=0 behaves as len=1.
- req_vec=1001 while req=1 → RST fetch at FFFE/FFFF, rdata = stored vector, is_vec=1; ordinary req accepted on the same completing edge with no cs gap.
- Read, len=2, inc, addr FFFF → second byte at 0000. rst asserted mid-transfer → next edge cs=0, we=0, busy=0, no done pulse.
